// File: rtl/tea_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : tea_pkg                                                  |
// | Purpose   : Shared TEA constants and the match-checker FSM encoding. |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package tea_pkg;

  localparam logic [31:0] DELTA        = 32'h9e3779b9;
  localparam int          BLOCK_W      = 64;
  localparam int          KEY_W        = 128;
  localparam int          PIPE_LATENCY = 33;

  // Checker run phases
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/tea_dec_match_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : tea_dec_match_checker_if                                 |
// | Purpose   : Block-issue / decryptor-output bus and the match-tag     |
// |             valid/ready drain channel of the match checker.          |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface tea_dec_match_checker_if #(
  parameter int TAG_W = 32
) ();
  import tea_pkg::*;

  logic               in_valid;
  logic [TAG_W-1:0]   in_tag;
  logic [BLOCK_W-1:0] dec_block;
  logic               match_valid;
  logic [TAG_W-1:0]   match_tag;
  logic               match_ready;

  // Driver of blocks and consumer of match tags
  modport master (
    output in_valid, in_tag, dec_block, match_ready,
    input  match_valid, match_tag
  );

  // The checker itself
  modport slave (
    input  in_valid, in_tag, dec_block, match_ready,
    output match_valid, match_tag
  );

endinterface
`default_nettype wire

// File: rtl/tea_dec_match_checker_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tag_fifo                                                 |
// | Purpose   : Synchronous FIFO for match tags. A push while full is    |
// |             accepted only when a pop happens in the same cycle.      |
// |             clr empties the FIFO synchronously.                      |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tag_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; clear and reset both empty the queue
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are only visible through head when non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/tea_dec_match_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tea_dec_match_checker                                    |
// | Purpose   : Tracks blocks through the fixed-latency TEA decryptor,   |
// |             compares each result with the expected plaintext and     |
// |             queues tags of matching blocks for a valid/ready drain.  |
// | Options   : MATCH_MASK_EN - adds a 64-bit compare mask port.         |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tea_dec_match_checker
  import tea_pkg::*;
#(
  parameter int LATENCY    = PIPE_LATENCY,
  parameter int TAG_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TAG_W-1:0]   num_blocks,
  input  logic [BLOCK_W-1:0] expected,
`ifdef MATCH_MASK_EN
  input  logic [BLOCK_W-1:0] mask,
`endif
  tea_dec_match_checker_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic [TAG_W-1:0]   match_count,
  output logic               overflow
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  chk_state_t         state;
  chk_state_t         state_nxt;
  logic [TAG_W-1:0]   num_lat;
  logic [TAG_W-1:0]   issued;
  logic [BLOCK_W-1:0] exp_lat;
`ifdef MATCH_MASK_EN
  logic [BLOCK_W-1:0] mask_lat;
`endif
  logic               trk_valid [LATENCY];
  logic [TAG_W-1:0]   trk_tag   [LATENCY];
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   inflight_nxt;
  logic               start_ok;
  logic               accept;
  logic               last_issue;
  logic               head_valid;
  logic               hit;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               drop;
  logic [TAG_W-1:0]   fifo_head;

  assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
  assign accept     = (state == ST_RUN) && bus.in_valid;
  assign last_issue = accept && ((issued + TAG_W'(1)) == num_lat);
  assign head_valid = trk_valid[LATENCY-1];
`ifdef MATCH_MASK_EN
  assign hit        = (((bus.dec_block ^ exp_lat) & mask_lat) == '0);
`else
  assign hit        = (bus.dec_block == exp_lat);
`endif
  assign pop        = bus.match_valid && bus.match_ready;
  assign drop       = head_valid && hit && fifo_full && !pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: DRAIN ends once the compare in flight this cycle is the last one
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = (num_blocks == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:           if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN:         if (inflight_nxt == '0) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  // Run parameters captured on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      num_lat  <= '0;
      exp_lat  <= '0;
`ifdef MATCH_MASK_EN
      mask_lat <= '0;
`endif
    end else if (start_ok) begin
      num_lat  <= num_blocks;
      exp_lat  <= expected;
`ifdef MATCH_MASK_EN
      mask_lat <= mask;
`endif
    end
  end

  // Issued-block counter for the current run
  always_ff @(posedge clk) begin
    if (rst || start_ok) issued <= '0;
    else if (accept)     issued <= issued + TAG_W'(1);
  end

  // Tracking shift register; head entry lines up with its dec_block
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        trk_valid[i] <= 1'b0;
        trk_tag[i]   <= '0;
      end
    end else begin
      trk_valid[0] <= accept;
      trk_tag[0]   <= accept ? bus.in_tag : '0;
      for (int i = 1; i < LATENCY; i++) begin
        trk_valid[i] <= trk_valid[i-1];
        trk_tag[i]   <= trk_tag[i-1];
      end
    end
  end

  // Count of valid entries still inside the tracking register
  always_comb begin
    inflight_nxt = inflight;
    if (accept && !head_valid)      inflight_nxt = inflight + CNT_W'(1);
    else if (!accept && head_valid) inflight_nxt = inflight - CNT_W'(1);
  end

  // In-flight counter register
  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else     inflight <= inflight_nxt;
  end

  // Saturating match counter and sticky overflow, both cleared per run
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (head_valid && hit && (match_count != '1)) match_count <= match_count + TAG_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .push  (head_valid && hit),
    .pop   (pop),
    .din   (trk_tag[LATENCY-1]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign bus.match_valid = !fifo_empty;
  assign bus.match_tag   = fifo_head;

endmodule
`default_nettype wire
